// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and constants for the ring pattern decoder
package ring_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [1:0] DIR_NONE  = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;

   localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - combinational one-hot to index encoder with validity flag
module onehot_enc #(
   parameter int WIDTH = 8,
   localparam int IDXW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   output logic [IDXW-1:0]  idx,
   output logic             is_onehot
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (a[i]) begin
            idx = idx | IDXW'(i);
         end
      end
      // Clearing the lowest set bit leaves zero only when exactly one bit was set.
      is_onehot = (a != '0) && ((a & (a - ONE)) == '0);
   end

endmodule

// File: rtl/ring_pattern_decoder.sv
// rtl/ring_pattern_decoder.sv - rotating one-hot decoder: position, direction, lock and step errors
// Optional RING_DEC_STEP_CNT_EN builds the saturating step_cnt output.
module ring_pattern_decoder
   import ring_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LOCK_CNT  = 3,
   parameter int ERR_LIMIT = 2,
   localparam int IDXW     = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      A,
   input  logic                  pat_valid,
   output logic [IDXW-1:0]       pos,
   output logic [1:0]            dir,
   output logic                  locked,
   output logic                  err
`ifdef RING_DEC_STEP_CNT_EN
   ,
   output logic [STEP_CNT_W-1:0] step_cnt
`endif
);

   localparam int CNT_W  = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(ERR_LIMIT + 1);
   localparam int DW     = IDXW + 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

   logic [IDXW-1:0] enc_idx;
   logic            enc_onehot;

   onehot_enc #(.WIDTH(WIDTH)) u_enc (
      .a         (A),
      .idx       (enc_idx),
      .is_onehot (enc_onehot)
   );

   state_t              state_q, state_d;
   logic [IDXW-1:0]     pos_q, pos_d;
   logic [IDXW-1:0]     prev_q, prev_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [MISS_W-1:0]   miss_q, miss_d;
   logic [1:0]          cand_q, cand_d;
   logic [1:0]          dir_q, dir_d;
   logic                locked_q, locked_d;
   logic                err_q, err_d;
`ifdef RING_DEC_STEP_CNT_EN
   logic [STEP_CNT_W-1:0] step_q, step_d;
`endif

   logic [DW-1:0]   diff_wide;
   logic [IDXW-1:0] delta;
   logic            is_left, is_right;
   logic [1:0]      cand_new;
   logic [IDXW-1:0] exp_idx;

   // Modular distance from the previous index; widening absorbs the borrow on wrap.
   always_comb begin
      diff_wide = {1'b0, enc_idx} - {1'b0, prev_q};
      if (enc_idx < prev_q) begin
         diff_wide = diff_wide + DW'(WIDTH);
      end
      delta    = diff_wide[IDXW-1:0];
      is_left  = (delta == IDXW'(1));
      is_right = (delta == LAST_IDX);
      cand_new = is_left ? DIR_LEFT : DIR_RIGHT;
      if (dir_q == DIR_LEFT) begin
         exp_idx = (prev_q == LAST_IDX) ? '0 : prev_q + IDXW'(1);
      end else begin
         exp_idx = (prev_q == '0) ? LAST_IDX : prev_q - IDXW'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      prev_d   = prev_q;
      cnt_d    = cnt_q;
      miss_d   = miss_q;
      cand_d   = cand_q;
      dir_d    = dir_q;
      locked_d = locked_q;
      err_d    = 1'b0;
`ifdef RING_DEC_STEP_CNT_EN
      step_d   = step_q;
`endif
      if (pat_valid) begin
         case (state_q)
            SEARCH: begin
               if (enc_onehot) begin
                  prev_d  = enc_idx;
                  pos_d   = enc_idx;
                  cnt_d   = '0;
                  cand_d  = DIR_NONE;
                  state_d = TRACK;
               end
            end
            TRACK: begin
               if (!enc_onehot) begin
                  cnt_d   = '0;
                  state_d = SEARCH;
               end else if (is_left || is_right) begin
                  if ((cand_new == cand_q) || (cnt_q == '0)) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end else begin
                     cnt_d = CNT_W'(1);
                  end
                  cand_d = cand_new;
                  prev_d = enc_idx;
                  pos_d  = enc_idx;
                  if (cnt_d == CNT_W'(LOCK_CNT)) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                     dir_d    = cand_new;
                     miss_d   = '0;
`ifdef RING_DEC_STEP_CNT_EN
                     step_d   = '0;
`endif
                  end
               end else begin
                  prev_d = enc_idx;
                  cnt_d  = '0;
               end
            end
            LOCKED: begin
               if (enc_onehot && (enc_idx == exp_idx)) begin
                  pos_d  = enc_idx;
                  prev_d = enc_idx;
                  miss_d = '0;
`ifdef RING_DEC_STEP_CNT_EN
                  if (step_q != '1) begin
                     step_d = step_q + STEP_CNT_W'(1);
                  end
`endif
               end else begin
                  err_d  = 1'b1;
                  miss_d = miss_q + MISS_W'(1);
                  if (miss_d == MISS_W'(ERR_LIMIT)) begin
                     state_d  = SEARCH;
                     locked_d = 1'b0;
                     dir_d    = DIR_NONE;
                     miss_d   = '0;
                     cnt_d    = '0;
                  end
               end
            end
            default: begin
               state_d = SEARCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SEARCH;
         pos_q    <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         miss_q   <= '0;
         cand_q   <= DIR_NONE;
         dir_q    <= DIR_NONE;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
`ifdef RING_DEC_STEP_CNT_EN
         step_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         miss_q   <= miss_d;
         cand_q   <= cand_d;
         dir_q    <= dir_d;
         locked_q <= locked_d;
         err_q    <= err_d;
`ifdef RING_DEC_STEP_CNT_EN
         step_q   <= step_d;
`endif
      end
   end

   assign pos    = pos_q;
   assign dir    = dir_q;
   assign locked = locked_q;
   assign err    = err_q;
`ifdef RING_DEC_STEP_CNT_EN
   assign step_cnt = step_q;
`endif

endmodule

// File: tb/tb_ring_pattern_decoder.sv
// tb/tb_ring_pattern_decoder.sv - directed self-checking bench for ring_pattern_decoder
module tb_ring_pattern_decoder;

   logic        clk;
   logic        rst;
   logic [7:0]  A;
   logic        pat_valid;
   logic [2:0]  pos;
   logic [1:0]  dir;
   logic        locked;
   logic        err;
`ifdef RING_DEC_STEP_CNT_EN
   logic [15:0] step_cnt;
`endif

   int tests;
   int failed;

   ring_pattern_decoder #(.WIDTH(8), .LOCK_CNT(3), .ERR_LIMIT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .pat_valid (pat_valid),
      .pos       (pos),
      .dir       (dir),
      .locked    (locked),
      .err       (err)
`ifdef RING_DEC_STEP_CNT_EN
      ,
      .step_cnt  (step_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic [2:0] p, input logic [1:0] d,
                       input logic l, input logic e);
      chk({tag, ".pos"}, {29'd0, pos}, {29'd0, p});
      chk({tag, ".dir"}, {30'd0, dir}, {30'd0, d});
      chk({tag, ".locked"}, {31'd0, locked}, {31'd0, l});
      chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
   endtask

   task automatic drive(input logic r, input logic [7:0] a, input logic v);
      @(negedge clk);
      rst       = r;
      A         = a;
      pat_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input logic [7:0] a);
      drive(1'b0, a, 1'b1);
   endtask

   initial begin
      tests     = 0;
      failed    = 0;
      rst       = 1'b1;
      A         = 8'h00;
      pat_valid = 1'b0;

      drive(1'b1, 8'h01, 1'b1);
      drive(1'b1, 8'h01, 1'b1);
      outs("reset", 3'd0, 2'b00, 1'b0, 1'b0);
`ifdef RING_DEC_STEP_CNT_EN
      chk("reset.step_cnt", {16'd0, step_cnt}, 32'd0);
`endif

      // Left lock: fourth clean sample sets lock
      steps(8'h01); outs("left1", 3'd0, 2'b00, 1'b0, 1'b0);
      steps(8'h02); outs("left2", 3'd1, 2'b00, 1'b0, 1'b0);
      steps(8'h04); outs("left3", 3'd2, 2'b00, 1'b0, 1'b0);
      steps(8'h08); outs("left4", 3'd3, 2'b01, 1'b1, 1'b0);
`ifdef RING_DEC_STEP_CNT_EN
      chk("left4.step_cnt", {16'd0, step_cnt}, 32'd0);
`endif

      // Left steps through the 7 -> 0 wrap
      steps(8'h10); outs("lw4", 3'd4, 2'b01, 1'b1, 1'b0);
      steps(8'h20); outs("lw5", 3'd5, 2'b01, 1'b1, 1'b0);
      steps(8'h40); outs("lw6", 3'd6, 2'b01, 1'b1, 1'b0);
      steps(8'h80); outs("lw7", 3'd7, 2'b01, 1'b1, 1'b0);
      steps(8'h01); outs("lw0", 3'd0, 2'b01, 1'b1, 1'b0);
`ifdef RING_DEC_STEP_CNT_EN
      chk("lw0.step_cnt", {16'd0, step_cnt}, 32'd5);
`endif
      steps(8'h02); outs("lw1", 3'd1, 2'b01, 1'b1, 1'b0);
      steps(8'h04); outs("lw2", 3'd2, 2'b01, 1'b1, 1'b0);

      // Errors while locked at pos 2
      steps(8'h03); outs("bad_multi", 3'd2, 2'b01, 1'b1, 1'b1);
      steps(8'h08); outs("recover", 3'd3, 2'b01, 1'b1, 1'b0);
`ifdef RING_DEC_STEP_CNT_EN
      chk("recover.step_cnt", {16'd0, step_cnt}, 32'd8);
`endif
      steps(8'h00); outs("zero1", 3'd3, 2'b01, 1'b1, 1'b1);
      steps(8'h00); outs("zero2", 3'd3, 2'b00, 1'b0, 1'b1);

      // Right lock with 0 -> 7 wrap, starting from SEARCH
      steps(8'h01); outs("right1", 3'd0, 2'b00, 1'b0, 1'b0);
      steps(8'h80); outs("right2", 3'd7, 2'b00, 1'b0, 1'b0);
      steps(8'h40); outs("right3", 3'd6, 2'b00, 1'b0, 1'b0);
      steps(8'h20); outs("right4", 3'd5, 2'b10, 1'b1, 1'b0);

      // Stall: pat_valid low with junk on A
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 8'hFF, 1'b0);
         outs("stall", 3'd5, 2'b10, 1'b1, 1'b0);
      end

      // Reset overrides a valid good step
      drive(1'b1, 8'h10, 1'b1);
      outs("midrst", 3'd0, 2'b00, 1'b0, 1'b0);
`ifdef RING_DEC_STEP_CNT_EN
      chk("midrst.step_cnt", {16'd0, step_cnt}, 32'd0);
`endif

      // A repeated index (delta 0) restarts the consistency count
      steps(8'h01); outs("d0_a", 3'd0, 2'b00, 1'b0, 1'b0);
      steps(8'h02); outs("d0_b", 3'd1, 2'b00, 1'b0, 1'b0);
      steps(8'h02); chk("d0_c.locked", {31'd0, locked}, 32'd0);
      steps(8'h04); chk("d0_d.locked", {31'd0, locked}, 32'd0);
      steps(8'h08); outs("d0_e", 3'd3, 2'b00, 1'b0, 1'b0);
      steps(8'h10); outs("d0_f", 3'd4, 2'b01, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
